// File: rtl/phy_pkg.sv
`default_nettype none
// ============================================================================
// Package  : phy_pkg
// Brief    : Lane symbol constants and RX alignment FSM encoding (shared w/ TX).
// Revision : 1.0 - initial release
// ============================================================================
package phy_pkg;

    localparam logic [7:0] COM_SYM        = 8'hBC;
    localparam int         LOCK_COUNT_DEF = 4;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/byte_packer.sv
`default_nettype none
// ============================================================================
// Module   : byte_packer
// Brief    : Packs aligned data bytes into 32-bit words, first byte in [31:24].
// Revision : 1.0 - initial release
// ============================================================================
module byte_packer (
    input  logic        clk_32f,
    input  logic        reset,
    input  logic [7:0]  byte_data,
    input  logic        byte_valid,
    input  logic        com_seen,
    output logic [31:0] data_out,
    output logic        valid_out,
    output logic        frame_err
);

    logic [1:0]  widx;
    logic [23:0] word;

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            widx      <= 2'd0;
            word      <= 24'd0;
            data_out  <= 32'd0;
            valid_out <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            frame_err <= 1'b0;
            if (byte_valid) begin
                case (widx)
                    2'd0:    word[23:16] <= byte_data;
                    2'd1:    word[15:8]  <= byte_data;
                    2'd2:    word[7:0]   <= byte_data;
                    default: begin
                        data_out  <= {word, byte_data};
                        valid_out <= 1'b1;
                    end
                endcase
                // Index wraps 3 -> 0 naturally after the word completes
                widx <= widx + 2'd1;
            end else if (com_seen && (widx != 2'd0)) begin
                widx      <= 2'd0;
                frame_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/phy_rx_lane.sv
`default_nettype none
// ============================================================================
// Module   : phy_rx_lane
// Brief    : One PHY RX lane: deserializer, COM alignment FSM, optional packer.
// Config   : define PHY_RX_WORD_ASM_EN to build the 8->32 word packer.
// Revision : 1.0 - initial release
// ============================================================================
module phy_rx_lane #(
    parameter logic [7:0] COM_SYM    = phy_pkg::COM_SYM,
    parameter int         LOCK_COUNT = phy_pkg::LOCK_COUNT_DEF
) (
    input  logic        clk_32f,
    input  logic        reset,
    input  logic        data_in,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    output logic [31:0] data_out,
    output logic        valid_out,
    output logic        active,
    output logic        frame_err
);

    import phy_pkg::*;

    localparam int              CNT_W     = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_COUNT - 1);

    rx_state_t        state;
    logic [7:0]       sr;
    logic [2:0]       bit_cnt;
    logic [CNT_W-1:0] com_cnt;

    logic [7:0] nxt;
    logic       is_com;
    logic       boundary;
    logic       byte_stb;
    logic       com_stb;

    assign nxt      = {sr[6:0], data_in};
    assign is_com   = (nxt == COM_SYM);
    assign boundary = (bit_cnt == 3'd7);
    assign byte_stb = (state == LOCKED) && boundary && !is_com;
    assign com_stb  = (state == LOCKED) && boundary &&  is_com;

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            state      <= SEARCH;
            sr         <= 8'd0;
            bit_cnt    <= 3'd0;
            com_cnt    <= '0;
            byte_out   <= 8'd0;
            byte_valid <= 1'b0;
            active     <= 1'b0;
        end else begin
            sr         <= nxt;
            byte_valid <= 1'b0;
            case (state)
                SEARCH: begin
                    // Bit-sliding: any bit position may start a symbol
                    if (is_com) begin
                        bit_cnt <= 3'd0;
                        com_cnt <= CNT_W'(1);
                        if (LOCK_COUNT == 1) begin
                            state  <= LOCKED;
                            active <= 1'b1;
                        end else begin
                            state <= ALIGN;
                        end
                    end
                end
                ALIGN: begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (boundary) begin
                        if (is_com) begin
                            com_cnt <= com_cnt + CNT_W'(1);
                            if (com_cnt == LOCK_LAST) begin
                                state  <= LOCKED;
                                active <= 1'b1;
                            end
                        end else begin
                            com_cnt <= '0;
                            bit_cnt <= 3'd0;
                            state   <= SEARCH;
                        end
                    end
                end
                LOCKED: begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (byte_stb) begin
                        byte_out   <= nxt;
                        byte_valid <= 1'b1;
                    end
                end
                default: state <= SEARCH;
            endcase
        end
    end

`ifdef PHY_RX_WORD_ASM_EN
    byte_packer u_byte_packer (
        .clk_32f    (clk_32f),
        .reset      (reset),
        .byte_data  (nxt),
        .byte_valid (byte_stb),
        .com_seen   (com_stb),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .frame_err  (frame_err)
    );
`else
    assign data_out  = 32'd0;
    assign valid_out = 1'b0;
    assign frame_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_phy_rx_lane.sv
`default_nettype none
// ============================================================================
// Module   : tb_phy_rx_lane
// Brief    : Directed, table-driven bench for phy_rx_lane (either packer build).
// Revision : 1.0 - initial release
// ============================================================================
module tb_phy_rx_lane;

`ifdef PHY_RX_WORD_ASM_EN
    localparam bit ASM = 1'b1;
`else
    localparam bit ASM = 1'b0;
`endif

    logic        clk_32f = 1'b0;
    logic        reset   = 1'b0;
    logic        data_in = 1'b0;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic [31:0] data_out;
    logic        valid_out;
    logic        active;
    logic        frame_err;

    int checks   = 0;
    int failures = 0;

    phy_rx_lane dut (
        .clk_32f    (clk_32f),
        .reset      (reset),
        .data_in    (data_in),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .active     (active),
        .frame_err  (frame_err)
    );

    always #5 clk_32f = ~clk_32f;

    typedef struct {
        logic [7:0]  tx;
        logic        exp_bv;
        logic [7:0]  exp_byte;
        logic        exp_vo;
        logic [31:0] exp_data;
        logic        exp_fe;
        logic        exp_act;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(input logic [7:0] tx, input logic bv, input logic [7:0] b,
                                input logic vo, input logic [31:0] d, input logic fe,
                                input logic act);
        vec_t v;
        v.tx = tx; v.exp_bv = bv; v.exp_byte = b; v.exp_vo = vo;
        v.exp_data = d; v.exp_fe = fe; v.exp_act = act;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk_32f);
        data_in = b;
        @(posedge clk_32f);
        #1;
    endtask

    // Counts pulses seen before the 8th bit, where none may appear
    task automatic send_byte(input logic [7:0] b, output int stray_n);
        stray_n = 0;
        for (int i = 7; i >= 0; i--) begin
            send_bit(b[i]);
            if (i != 0 && (byte_valid || valid_out || frame_err)) stray_n++;
        end
    endtask

    task automatic apply(input string tag, input vec_t v);
        int s;
        send_byte(v.tx, s);
        chk({tag, ".stray"},      64'(s),          64'd0);
        chk({tag, ".byte_valid"}, 64'(byte_valid), 64'(v.exp_bv));
        chk({tag, ".byte_out"},   64'(byte_out),   64'(v.exp_byte));
        chk({tag, ".valid_out"},  64'(valid_out),  64'(v.exp_vo));
        chk({tag, ".data_out"},   64'(data_out),   64'(v.exp_data));
        chk({tag, ".frame_err"},  64'(frame_err),  64'(v.exp_fe));
        chk({tag, ".active"},     64'(active),     64'(v.exp_act));
    endtask

    task automatic chk_zero(input string name);
        chk(name, 64'({byte_out, byte_valid, data_out, valid_out, active, frame_err}), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w1, w2;
        logic [2:0]  junk;
        w1   = ASM ? 32'hDEADBEEF : 32'd0;
        w2   = ASM ? 32'h01020304 : 32'd0;
        junk = 3'b101;

        vecs[0]  = mk(8'hBC, 0, 8'h00, 0,   32'd0, 0,   0);
        vecs[1]  = mk(8'hBC, 0, 8'h00, 0,   32'd0, 0,   0);
        vecs[2]  = mk(8'hBC, 0, 8'h00, 0,   32'd0, 0,   0);
        vecs[3]  = mk(8'hBC, 0, 8'h00, 0,   32'd0, 0,   1);
        vecs[4]  = mk(8'hDE, 1, 8'hDE, 0,   32'd0, 0,   1);
        vecs[5]  = mk(8'hAD, 1, 8'hAD, 0,   32'd0, 0,   1);
        vecs[6]  = mk(8'hBE, 1, 8'hBE, 0,   32'd0, 0,   1);
        vecs[7]  = mk(8'hEF, 1, 8'hEF, ASM, w1,    0,   1);
        vecs[8]  = mk(8'h11, 1, 8'h11, 0,   w1,    0,   1);
        vecs[9]  = mk(8'h22, 1, 8'h22, 0,   w1,    0,   1);
        vecs[10] = mk(8'hBC, 0, 8'h22, 0,   w1,    ASM, 1);
        vecs[11] = mk(8'h01, 1, 8'h01, 0,   w1,    0,   1);
        vecs[12] = mk(8'h02, 1, 8'h02, 0,   w1,    0,   1);
        vecs[13] = mk(8'h03, 1, 8'h03, 0,   w1,    0,   1);
        vecs[14] = mk(8'h04, 1, 8'h04, ASM, w2,    0,   1);
        vecs[15] = mk(8'hBC, 0, 8'h04, 0,   w2,    0,   1);

        // Reset held with random line activity
        for (int i = 0; i < 20; i++) begin
            send_bit(1'($urandom));
            chk_zero($sformatf("reset.cyc%0d", i));
        end
        @(negedge clk_32f);
        reset = 1'b1;

        for (int i = 2; i >= 0; i--) send_bit(junk[i]);
        chk("junk.active", 64'(active), 64'd0);

        for (int i = 0; i < 16; i++) apply($sformatf("vec%0d", i), vecs[i]);

        // Broken COM run drops back to SEARCH, then relocks
        @(negedge clk_32f);
        reset = 1'b0;
        send_bit(1'b0);
        chk_zero("t5.reset");
        @(negedge clk_32f);
        reset = 1'b1;
        apply("t5.bc1", mk(8'hBC, 0, 8'h00, 0, 32'd0, 0, 0));
        apply("t5.bc2", mk(8'hBC, 0, 8'h00, 0, 32'd0, 0, 0));
        apply("t5.z00", mk(8'h00, 0, 8'h00, 0, 32'd0, 0, 0));
        apply("t5.bc3", mk(8'hBC, 0, 8'h00, 0, 32'd0, 0, 0));
        apply("t5.bc4", mk(8'hBC, 0, 8'h00, 0, 32'd0, 0, 0));
        apply("t5.bc5", mk(8'hBC, 0, 8'h00, 0, 32'd0, 0, 0));
        apply("t5.bc6", mk(8'hBC, 0, 8'h00, 0, 32'd0, 0, 1));

        // Reset mid-word, then relock and confirm the packer restarts at byte 0
        apply("t6.b11", mk(8'h11, 1, 8'h11, 0, 32'd0, 0, 1));
        apply("t6.b22", mk(8'h22, 1, 8'h22, 0, 32'd0, 0, 1));
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        #2 reset = 1'b0;
        #1 chk_zero("t6.async");
        for (int i = 0; i < 3; i++) begin
            send_bit(1'($urandom));
            chk_zero($sformatf("t6.hold%0d", i));
        end
        @(negedge clk_32f);
        reset = 1'b1;
        apply("t6.b33", mk(8'h33, 0, 8'h00, 0, 32'd0, 0, 0));
        apply("t6.b44", mk(8'h44, 0, 8'h00, 0, 32'd0, 0, 0));
        apply("t6.b55", mk(8'h55, 0, 8'h00, 0, 32'd0, 0, 0));
        apply("t6.b66", mk(8'h66, 0, 8'h00, 0, 32'd0, 0, 0));
        apply("t6.bc1", mk(8'hBC, 0, 8'h00, 0, 32'd0, 0, 0));
        apply("t6.bc2", mk(8'hBC, 0, 8'h00, 0, 32'd0, 0, 0));
        apply("t6.bc3", mk(8'hBC, 0, 8'h00, 0, 32'd0, 0, 0));
        apply("t6.bc4", mk(8'hBC, 0, 8'h00, 0, 32'd0, 0, 1));
        apply("t6.w01", mk(8'h01, 1, 8'h01, 0,   32'd0, 0, 1));
        apply("t6.w02", mk(8'h02, 1, 8'h02, 0,   32'd0, 0, 1));
        apply("t6.w03", mk(8'h03, 1, 8'h03, 0,   32'd0, 0, 1));
        apply("t6.w04", mk(8'h04, 1, 8'h04, ASM, w2,    0, 1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
